// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage with SRAM-like data port; optional MEM_LOAD_FWD_EN
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EX_to_MEM,
  input  logic [31:0] ex_pc,
  input  logic        ex_gr_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_res_from_mem,
  input  logic        ex_mem_we,
  input  logic [4:0]  ex_ld_op,
  input  logic [2:0]  ex_st_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_result,
  input  logic [14:0] ex_except,
  output logic        MEM_allowin,
  output logic        MEM_to_WB,
  input  logic        WB_allowin,
  output logic [31:0] wb_pc,
  output logic        wb_gr_we,
  output logic [4:0]  wb_rf_waddr,
  output logic [31:0] wb_rf_wdata,
  output logic [14:0] wb_except,
  output logic        front_valid,
  output logic [4:0]  front_addr,
  output logic [31:0] front_data,
  output logic        MEM_is_load,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t      r_state;
  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_gr_we;
  logic [4:0]  r_rf_waddr;
  logic        r_res_from_mem;
  logic        r_mem_we;
  logic [4:0]  r_ld_op;
  logic [2:0]  r_st_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_result;
  logic [14:0] r_except;
  logic [31:0] r_rdata;

  logic        w_latch;
  logic        w_go_req;
  logic        w_fwd_now;
  logic [31:0] w_wb_data;

  // Byte/halfword lane select by address offset; ld_op is one-hot {b,bu,h,hu,w}
  function automatic logic [31:0] load_extract(input logic [4:0] ld_op, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    if (ld_op[4])      return {{24{sh[7]}}, sh[7:0]};
    else if (ld_op[3]) return {24'd0, sh[7:0]};
    else if (ld_op[2]) return {{16{sh[15]}}, sh[15:0]};
    else if (ld_op[1]) return {16'd0, sh[15:0]};
    else               return rdata;
  endfunction

  assign w_go_req    = (ex_res_from_mem | ex_mem_we) & (ex_except == 15'd0);
  assign MEM_to_WB   = r_valid & (r_state == S_DONE) & WB_allowin & ~flush;
  assign MEM_allowin = (~r_valid | MEM_to_WB) & (r_state != S_CANCEL);
  assign w_latch     = EX_to_MEM & MEM_allowin & ~flush;

  // A flush without a same-cycle address handshake withdraws the request immediately
  assign data_sram_req   = (r_state == S_REQ) & (~flush | data_sram_addr_ok);
  assign data_sram_wr    = r_mem_we;
  assign data_sram_addr  = r_addr;
  assign data_sram_size  = (r_ld_op[4] | r_ld_op[3] | r_st_op[2]) ? 2'd0 :
                           (r_ld_op[2] | r_ld_op[1] | r_st_op[1]) ? 2'd1 : 2'd2;
  assign data_sram_wstrb = ~r_mem_we  ? 4'b0000 :
                           r_st_op[2] ? (4'b0001 << r_addr[1:0]) :
                           r_st_op[1] ? (4'b0011 << r_addr[1:0]) : 4'b1111;
  assign data_sram_wdata = r_st_op[2] ? {4{r_wdata[7:0]}} :
                           r_st_op[1] ? {2{r_wdata[15:0]}} : r_wdata;

  assign w_wb_data   = r_res_from_mem ? load_extract(r_ld_op, r_addr[1:0], r_rdata) : r_result;
  assign wb_pc       = r_pc;
  assign wb_gr_we    = r_gr_we;
  assign wb_rf_waddr = r_rf_waddr;
  assign wb_rf_wdata = w_wb_data;
  assign wb_except   = r_except;

`ifdef MEM_LOAD_FWD_EN
  // Load result is visible to ID as soon as the response arrives
  assign w_fwd_now = r_valid & r_res_from_mem & (r_state == S_WAIT) & data_sram_data_ok & ~flush;
`else
  assign w_fwd_now = 1'b0;
`endif

  assign front_valid = r_valid & r_gr_we & ((r_state == S_DONE) | ~r_res_from_mem | w_fwd_now);
  assign front_addr  = r_rf_waddr;
  assign front_data  = w_fwd_now ? load_extract(r_ld_op, r_addr[1:0], data_sram_rdata) : w_wb_data;
  assign MEM_is_load = r_valid & r_res_from_mem & (r_state != S_DONE);

  // Stage FSM plus payload capture; a new op may enter in the same cycle DONE hands off
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_valid        <= 1'b0;
      r_pc           <= 32'd0;
      r_gr_we        <= 1'b0;
      r_rf_waddr     <= 5'd0;
      r_res_from_mem <= 1'b0;
      r_mem_we       <= 1'b0;
      r_ld_op        <= 5'd0;
      r_st_op        <= 3'd0;
      r_addr         <= 32'd0;
      r_wdata        <= 32'd0;
      r_result       <= 32'd0;
      r_except       <= 15'd0;
      r_rdata        <= 32'd0;
    end else if (w_latch) begin
      r_valid        <= 1'b1;
      r_state        <= w_go_req ? S_REQ : S_DONE;
      r_pc           <= ex_pc;
      r_gr_we        <= ex_gr_we;
      r_rf_waddr     <= ex_rf_waddr;
      r_res_from_mem <= ex_res_from_mem;
      r_mem_we       <= ex_mem_we;
      r_ld_op        <= ex_ld_op;
      r_st_op        <= ex_st_op;
      r_addr         <= ex_addr;
      r_wdata        <= ex_wdata;
      r_result       <= ex_result;
      r_except       <= ex_except;
    end else begin
      case (r_state)
        S_IDLE: r_valid <= 1'b0;
        S_REQ: begin
          if (flush) begin
            r_valid <= 1'b0;
            r_state <= data_sram_addr_ok ? S_CANCEL : S_IDLE;
          end else if (data_sram_addr_ok) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_sram_data_ok) begin
            r_rdata <= data_sram_rdata;
            if (flush) begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
            end
          end else if (flush) begin
            r_valid <= 1'b0;
            r_state <= S_CANCEL;
          end
        end
        S_DONE: begin
          if (flush || MEM_to_WB) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_CANCEL: if (data_sram_data_ok) r_state <= S_IDLE;
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; resetn in 1, reset, asynchronous, active-low.
REQ-002 SHALL have EX side: EX_to_MEM in 1 (load strobe); ex_pc in 32; ex_gr_we in 1; ex_rf_waddr in 5; ex_res_from_mem in 1; ex_mem_we in 1; ex_ld_op in 5 (one-hot {b,bu,h,hu,w}); ex_st_op in 3 (one-hot {b,h,w}); ex_addr in 32 (translated); ex_wdata in 32 (store data); ex_result in 32; ex_except in 15; MEM_allowin out 1.
REQ-003 SHALL have WB side: MEM_to_WB out 1; WB_allowin in 1; wb_pc out 32; wb_gr_we out 1; wb_rf_waddr out 5; wb_rf_wdata out 32; wb_except out 15.
REQ-004 SHALL have ID side: front_valid out 1; front_addr out 5; front_data out 32; MEM_is_load out 1 (valid load not yet complete).
REQ-005 SHALL have data SRAM side: data_sram_req out 1; data_sram_wr out 1; data_sram_size out 2; data_sram_addr out 32; data_sram_wstrb out 4; data_sram_wdata out 32; data_sram_addr_ok in 1; data_sram_data_ok in 1; data_sram_rdata in 32; flush in 1.

Function
REQ-006 SHALL latch all ex_* fields when EX_to_MEM=1; MEM_allowin = ~valid | MEM_to_WB, and SHALL be 0 in CANCEL.
REQ-007 SHALL implement states IDLE, REQ, WAIT, DONE, CANCEL.
REQ-008 On latch: a memory op (ex_res_from_mem|ex_mem_we) with ex_except==0 SHALL enter REQ; otherwise DONE.
REQ-009 In REQ: data_sram_req=1, with addr/size/wr/wstrb/wdata held constant; req&addr_ok SHALL move to WAIT.
REQ-010 In WAIT: data_ok SHALL capture rdata and move to DONE; req=0.
REQ-011 In DONE: MEM_to_WB = WB_allowin; handoff SHALL go to IDLE, or to REQ/DONE if a new op latches in the same cycle.
REQ-012 SHALL encode size: b=0, h=1, w=2; wstrb for st.b = 4'b0001<<addr[1:0], st.h = 4'b0011<<addr[1:0], st.w = 4'b1111; wdata SHALL replicate the byte or halfword across the lanes.
REQ-013 SHALL select load data by addr[1:0]: ld.b/ld.h sign-extend, ld.bu/ld.hu zero-extend, ld.w pass-through; non-loads SHALL pass ex_result.
REQ-014 Flush in REQ without addr_ok SHALL drop req the same cycle and go to IDLE; flush with addr_ok, or in WAIT, SHALL go to CANCEL.
REQ-015 In CANCEL: req=0; SHALL discard the data_ok response, then go to IDLE.
REQ-016 Flush in IDLE/DONE SHALL clear valid and go to IDLE; MEM_to_WB=0 in the flush cycle.
REQ-017 front_valid = valid & gr_we & (state==DONE, or non-load); MEM_is_load = valid & res_from_mem & state!=DONE.
REQ-018 wb_except SHALL equal the latched ex_except, unchanged.

Reset
REQ-019 On resetn=0 SHALL immediately force: state IDLE, valid 0, data_sram_req 0, MEM_to_WB 0, front_valid 0, MEM_is_load 0; latched payload SHALL clear to 0.
REQ-020 Reset in WAIT SHALL abandon the transaction; after reset, a late data_ok in IDLE SHALL be ignored.

Configuration
REQ-021 With MEM_LOAD_FWD_EN defined: in the data_ok cycle, front_valid=1 and front_data = extracted load data, one cycle earlier than DONE.
REQ-022 Without MEM_LOAD_FWD_EN: loads forward only from DONE.

Verification
REQ-023 ld.b at addr 0x1003, rdata 0x80FF_1234, addr_ok at cycle 1, data_ok at cycle 3 -> size 0; wb_rf_wdata 0xFFFF_FF80; MEM_to_WB at cycle 4.
REQ-024 st.h at addr 0x2002, wdata 0x0000_ABCD -> wstrb 4'b1100, data_sram_wdata 0xABCD_ABCD, wr 1, no load forward.
REQ-025 Load with flush in WAIT, data_ok 2 cycles later -> MEM_allowin 0 until data_ok, no MEM_to_WB, next op issues req afterwards.
REQ-026 Load with ex_except=15'h0040 -> data_sram_req never asserts; wb_except 15'h0040; DONE immediately.
REQ-027 Back-to-back ALU ops with WB_allowin=1 -> one MEM_to_WB per cycle, front_valid each cycle, data 0x5, 0x6.
REQ-028 With MEM_LOAD_FWD_EN: ld.w, rdata 0x1234_5678 -> front_valid and front_data 0x1234_5678 in the data_ok cycle.
